uart_rcvr: RTL and testbench

Serial-to-parallel UART receiver; the receiving end of the UART_XMTR link (start bit 0, `word_size` data bits LSB first, one stop bit 1, idle line 1). It oversamples `Serial_in` with a single system clock, confirms each start bit at mid-bit, and samples every data and stop bit at mid-bit. Each word is presented to the host on a parallel register with a valid/acknowledge handshake. Overrun and framing errors are flagged.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rcvr.sv | 143 ++++++++++++++
 tb/tb_uart_rcvr.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default frame geometry and line levels.
// Common to the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STARTING  = 2'd1,
        ST_RECEIVING = 2'd2
    } uart_state_t;

    localparam int DEFAULT_WORD_SIZE    = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw serial line, resetting to the idle level (1).
// Only built when UART_RCVR_SYNC_EN is defined, since nothing else instantiates it.
`ifdef UART_RCVR_SYNC_EN
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule
`endif

// File: rtl/uart_rcvr.sv
// UART receiver: oversampled start detection, mid-bit sampling, valid/ack host handshake
// with sticky overrun and framing flags. Define UART_RCVR_SYNC_EN to synchronize Serial_in.
module uart_rcvr
    import uart_pkg::*;
#(
    parameter int word_size    = DEFAULT_WORD_SIZE,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 Clock,
    input  logic                 rst,
    input  logic                 Serial_in,
    input  logic                 Read_ack,
    output logic [word_size-1:0] RCV_datareg,
    output logic                 Byte_valid,
    output logic                 Overrun_err,
    output logic                 Frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(word_size + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BITS_FULL = BW'(word_size);

    logic                 line;
    uart_state_t          state_reg, state_next;
    logic                 prev_reg;
    logic [CW-1:0]        sample_cnt_reg;
    logic [BW-1:0]        bit_cnt_reg;
    logic [word_size-1:0] rcv_shftreg_reg;
    logic                 start_det, start_ok, glitch, bit_tick, stop_tick, load_word;

`ifdef UART_RCVR_SYNC_EN
    uart_rx_sync u_sync (
        .clk (Clock),
        .rst (rst),
        .d   (Serial_in),
        .q   (line)
    );
`else
    assign line = Serial_in;
`endif

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_det) state_next = ST_STARTING;
            end
            ST_STARTING: begin
                if (glitch)        state_next = ST_IDLE;
                else if (start_ok) state_next = ST_RECEIVING;
            end
            ST_RECEIVING: begin
                if (stop_tick) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Per-state strobes; the sample tick at the end of the last bit period is the stop bit.
    always_comb begin
        start_det = 1'b0;
        start_ok  = 1'b0;
        glitch    = 1'b0;
        bit_tick  = 1'b0;
        stop_tick = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                start_det = (prev_reg == STOP_BIT) && (line == START_BIT);
            end
            ST_STARTING: begin
                glitch   = (line != START_BIT);
                start_ok = (line == START_BIT) && (sample_cnt_reg == HALF_LAST);
            end
            ST_RECEIVING: begin
                if (sample_cnt_reg == BIT_LAST) begin
                    bit_tick  = (bit_cnt_reg != BITS_FULL);
                    stop_tick = (bit_cnt_reg == BITS_FULL);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            prev_reg        <= STOP_BIT;
            sample_cnt_reg  <= '0;
            bit_cnt_reg     <= '0;
            rcv_shftreg_reg <= '0;
        end else begin
            prev_reg <= line;
            if (state_reg == ST_IDLE || state_next != state_reg || bit_tick) begin
                sample_cnt_reg <= '0;
            end else begin
                sample_cnt_reg <= sample_cnt_reg + 1'b1;
            end
            if (state_reg != ST_RECEIVING) begin
                bit_cnt_reg <= '0;
            end else if (bit_tick) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
            if (bit_tick) begin
                rcv_shftreg_reg <= {line, rcv_shftreg_reg[word_size-1:1]};
            end
        end
    end

    // An ack in the same cycle as a good stop bit frees the register for the new word.
    assign load_word = stop_tick && (line == STOP_BIT) && (!Byte_valid || Read_ack);

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            RCV_datareg <= '0;
            Byte_valid  <= 1'b0;
            Overrun_err <= 1'b0;
            Frame_err   <= 1'b0;
        end else if (load_word) begin
            RCV_datareg <= rcv_shftreg_reg;
            Byte_valid  <= 1'b1;
        end else begin
            if (Read_ack) begin
                Byte_valid  <= 1'b0;
                Overrun_err <= 1'b0;
                Frame_err   <= 1'b0;
            end
            if (stop_tick) begin
                if (line == STOP_BIT) Overrun_err <= 1'b1;
                else                  Frame_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rcvr.sv
// Self-checking bench for uart_rcvr: frames are scheduled as stop-edge events and a
// cycle-level compare process checks the outputs against the resulting expected state.
`timescale 1ns/1ps
module tb_uart_rcvr;

    localparam int CPB = 8;
`ifdef UART_RCVR_SYNC_EN
    localparam int STOP_EDGE = 78;
`else
    localparam int STOP_EDGE = 76;
`endif

    logic       Clock = 1'b0;
    logic       rst;
    logic       Serial_in;
    logic       Read_ack = 1'b0;
    logic [7:0] RCV_datareg;
    logic       Byte_valid, Overrun_err, Frame_err;

    uart_rcvr #(.word_size(8), .CLKS_PER_BIT(CPB)) dut (
        .Clock       (Clock),
        .rst         (rst),
        .Serial_in   (Serial_in),
        .Read_ack    (Read_ack),
        .RCV_datareg (RCV_datareg),
        .Byte_valid  (Byte_valid),
        .Overrun_err (Overrun_err),
        .Frame_err   (Frame_err)
    );

    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Edge numbering: at a negedge, edge_no is the number of the next rising edge.
    int edge_no = 0;
    always @(posedge Clock) edge_no <= edge_no + 1;

    // Scheduled frame completions: edge of the stop sample, word, stop-bit level.
    int         ev_edge[32];
    logic [7:0] ev_data[32];
    logic       ev_ok[32];
    int         ev_wr = 0;
    int         ev_rd = 0;

    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0, exp_ovr = 1'b0, exp_frm = 1'b0;

    always @(posedge Clock or posedge rst) begin
        if (rst) begin
            exp_data  <= 8'h00;
            exp_valid <= 1'b0;
            exp_ovr   <= 1'b0;
            exp_frm   <= 1'b0;
            ev_rd     <= ev_wr;
        end else if (ev_rd < ev_wr && ev_edge[ev_rd] == edge_no) begin
            ev_rd <= ev_rd + 1;
            if (!ev_ok[ev_rd]) begin
                exp_frm <= 1'b1;
                if (Read_ack) begin
                    exp_valid <= 1'b0;
                    exp_ovr   <= 1'b0;
                end
            end else if (exp_valid && !Read_ack) begin
                exp_ovr <= 1'b1;
            end else begin
                exp_data  <= ev_data[ev_rd];
                exp_valid <= 1'b1;
            end
        end else if (Read_ack) begin
            exp_valid <= 1'b0;
            exp_ovr   <= 1'b0;
            exp_frm   <= 1'b0;
        end
    end

    always @(negedge Clock) begin
        if (rst === 1'b0) begin
            check("cyc data",    {24'd0, RCV_datareg}, {24'd0, exp_data});
            check("cyc valid",   {31'd0, Byte_valid},  {31'd0, exp_valid});
            check("cyc overrun", {31'd0, Overrun_err}, {31'd0, exp_ovr});
            check("cyc framing", {31'd0, Frame_err},   {31'd0, exp_frm});
        end
    end

    // Host side: explicit ack at a chosen edge, or auto-ack one edge after each valid word.
    int         ack_edge = -1;
    logic       auto_ack = 1'b0;
    logic [7:0] rx_log[8];
    int         rx_n = 0;

    always @(negedge Clock) begin
        Read_ack <= (edge_no == ack_edge) || (auto_ack && Byte_valid && !Read_ack);
        if (auto_ack && Byte_valid && !Read_ack && rx_n < 8) begin
            rx_log[rx_n] <= RCV_datareg;
            rx_n         <= rx_n + 1;
        end
    end

    task automatic idle(input int n);
        Serial_in = 1'b1;
        repeat (n) @(negedge Clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        ev_edge[ev_wr] = edge_no + STOP_EDGE;
        ev_data[ev_wr] = d;
        ev_ok[ev_wr]   = stop_ok;
        ev_wr++;
        Serial_in = 1'b0;
        repeat (CPB) @(negedge Clock);
        for (int k = 0; k < 8; k++) begin
            Serial_in = d[k];
            repeat (CPB) @(negedge Clock);
        end
        Serial_in = stop_ok;
        repeat (CPB) @(negedge Clock);
        Serial_in = 1'b1;
        $display("frame %02h stop=%0b: data=%02h valid=%0b ovr=%0b frm=%0b",
                 d, stop_ok, RCV_datareg, Byte_valid, Overrun_err, Frame_err);
    endtask

    task automatic pulse_ack();
        ack_edge = edge_no + 1;
        repeat (3) @(negedge Clock);
        $display("ack: valid=%0b ovr=%0b frm=%0b", Byte_valid, Overrun_err, Frame_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] tb_byte;

    initial begin
        Serial_in = 1'b1;
        rst       = 1'b1;
        #1;
        check("reset data",    {24'd0, RCV_datareg}, 32'h0);
        check("reset valid",   {31'd0, Byte_valid},  32'h0);
        check("reset overrun", {31'd0, Overrun_err}, 32'h0);
        check("reset framing", {31'd0, Frame_err},   32'h0);
        repeat (3) @(negedge Clock);
        rst = 1'b0;
        idle(4);

        // Single frame with the exact completion edge pinned.
        fork
            send_frame(8'h41, 1'b1);
            begin
                repeat (STOP_EDGE) @(negedge Clock);
                check("t1 valid before stop edge", {31'd0, Byte_valid}, 32'h0);
                @(negedge Clock);
                check("t1 valid at stop edge", {31'd0, Byte_valid},  32'h1);
                check("t1 data",               {24'd0, RCV_datareg}, 32'h41);
                check("t1 no errors",          {30'd0, Overrun_err, Frame_err}, 32'h0);
            end
        join
        pulse_ack();
        check("t1 valid after ack", {31'd0, Byte_valid}, 32'h0);

        // Back-to-back frames with the host acking every word.
        auto_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tb_byte = 8'(8'h41 + i);
            send_frame(tb_byte, 1'b1);
        end
        idle(4);
        auto_ack = 1'b0;
        check("b2b word count", rx_n, 32'd5);
        for (int i = 0; i < 5; i++) begin
            tb_byte = 8'(8'h41 + i);
            check("b2b word order", {24'd0, rx_log[i]}, {24'd0, tb_byte});
        end
        check("b2b no errors", {30'd0, Overrun_err, Frame_err}, 32'h0);

        // Framing error, then a good frame while the flag is still held.
        send_frame(8'h55, 1'b0);
        idle(4);
        check("ferr flag",  {31'd0, Frame_err},   32'h1);
        check("ferr valid", {31'd0, Byte_valid},  32'h0);
        check("ferr data",  {24'd0, RCV_datareg}, 32'h45);
        send_frame(8'h42, 1'b1);
        idle(2);
        check("ferr next valid", {31'd0, Byte_valid},  32'h1);
        check("ferr next data",  {24'd0, RCV_datareg}, 32'h42);
        check("ferr still set",  {31'd0, Frame_err},   32'h1);
        pulse_ack();
        check("ferr cleared", {31'd0, Frame_err}, 32'h0);

        // Overrun: second word dropped while the first is unread.
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        idle(2);
        check("ovr data kept", {24'd0, RCV_datareg}, 32'h41);
        check("ovr flag",      {31'd0, Overrun_err}, 32'h1);
        pulse_ack();
        check("ovr cleared", {31'd0, Overrun_err}, 32'h0);

        // Ack coinciding with the stop edge lets the new word in.
        send_frame(8'h41, 1'b1);
        ack_edge = edge_no + STOP_EDGE;
        send_frame(8'h42, 1'b1);
        idle(2);
        check("ack@stop data",  {24'd0, RCV_datareg}, 32'h42);
        check("ack@stop valid", {31'd0, Byte_valid},  32'h1);
        check("ack@stop no ovr", {31'd0, Overrun_err}, 32'h0);
        pulse_ack();

        // Short low pulse must not start a frame.
        Serial_in = 1'b0;
        repeat (2) @(negedge Clock);
        idle(20);
        $display("glitch: valid=%0b data=%02h", Byte_valid, RCV_datareg);
        check("glitch valid", {31'd0, Byte_valid},  32'h0);
        check("glitch data",  {24'd0, RCV_datareg}, 32'h42);
        send_frame(8'h43, 1'b1);
        idle(2);
        check("post-glitch data",  {24'd0, RCV_datareg}, 32'h43);
        check("post-glitch valid", {31'd0, Byte_valid},  32'h1);

        // Reset during data bit 3 of 0x44 (word 0x43 still unread).
        tb_byte = 8'h44;
        Serial_in = 1'b0;
        repeat (CPB) @(negedge Clock);
        for (int k = 0; k < 3; k++) begin
            Serial_in = tb_byte[k];
            repeat (CPB) @(negedge Clock);
        end
        Serial_in = tb_byte[3];
        repeat (CPB / 2) @(negedge Clock);
        Serial_in = 1'b1;
        rst = 1'b1;
        #1;
        $display("reset mid-frame: data=%02h valid=%0b", RCV_datareg, Byte_valid);
        check("midrst data",    {24'd0, RCV_datareg}, 32'h0);
        check("midrst valid",   {31'd0, Byte_valid},  32'h0);
        check("midrst overrun", {31'd0, Overrun_err}, 32'h0);
        check("midrst framing", {31'd0, Frame_err},   32'h0);
        repeat (2) @(negedge Clock);
        rst = 1'b0;
        idle(10);
        send_frame(8'h45, 1'b1);
        idle(2);
        check("post-reset data",  {24'd0, RCV_datareg}, 32'h45);
        check("post-reset valid", {31'd0, Byte_valid},  32'h1);
        check("post-reset no errors", {30'd0, Overrun_err, Frame_err}, 32'h0);
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
